// File: rtl/mdu_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_t;

    typedef struct packed {
        logic is_div;
        logic signA;
        logic signB;
        logic sel_high;
        logic sel_rem;
    } mdu_ctrl_t;

endpackage

// File: rtl/mdu_dec.sv
// funct3 decode for the M extension: operand signedness and result selection.
module mdu_dec
    import mdu_pkg::*;
(
    input  logic [2:0] funct3_i,
    output mdu_ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (funct3_i)
            OP_MUL:    ctrl_o = '{is_div: 1'b0, signA: 1'b1, signB: 1'b1, sel_high: 1'b0, sel_rem: 1'b0};
            OP_MULH:   ctrl_o = '{is_div: 1'b0, signA: 1'b1, signB: 1'b1, sel_high: 1'b1, sel_rem: 1'b0};
            OP_MULHSU: ctrl_o = '{is_div: 1'b0, signA: 1'b1, signB: 1'b0, sel_high: 1'b1, sel_rem: 1'b0};
            OP_MULHU:  ctrl_o = '{is_div: 1'b0, signA: 1'b0, signB: 1'b0, sel_high: 1'b1, sel_rem: 1'b0};
            OP_DIV:    ctrl_o = '{is_div: 1'b1, signA: 1'b1, signB: 1'b1, sel_high: 1'b0, sel_rem: 1'b0};
            OP_DIVU:   ctrl_o = '{is_div: 1'b1, signA: 1'b0, signB: 1'b0, sel_high: 1'b0, sel_rem: 1'b0};
            OP_REM:    ctrl_o = '{is_div: 1'b1, signA: 1'b1, signB: 1'b1, sel_high: 1'b0, sel_rem: 1'b1};
            OP_REMU:   ctrl_o = '{is_div: 1'b1, signA: 1'b0, signB: 1'b0, sel_high: 1'b0, sel_rem: 1'b1};
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative multiply/divide for the Execute stage: one bit per cycle on operand
// magnitudes, sign fixed up on the way into DONE; div-by-zero/overflow bypass CALC.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StartE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            BusyE,
    output logic            DoneE,
    output logic [XLEN-1:0] ResultE
);

    localparam int CNT_W = $clog2(XLEN + 1);

    mdu_state_t        state_q;
    mdu_ctrl_t         ctrl_d;
    logic              is_div_q, sel_high_q, sel_rem_q, neg_q, done_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   opnd_q, rem_q, rem_d, result_q;
    logic [2*XLEN-1:0] acc_q, acc_d, mul_acc, div_acc, prod;
    logic [XLEN:0]     mul_sum, shifted, sub;
    logic              borrow, negA, negB, start, div_zero, div_ovf;
    logic [XLEN-1:0]   magA, magB, fast_res, div_val, div_res, calc_res;

    mdu_dec u_dec (.funct3_i(funct3E), .ctrl_o(ctrl_d));

    assign negA     = ctrl_d.signA & SrcAE[XLEN-1];
    assign negB     = ctrl_d.signB & SrcBE[XLEN-1];
    assign magA     = negA ? -SrcAE : SrcAE;
    assign magB     = negB ? -SrcBE : SrcBE;
    assign start    = (state_q == IDLE) && StartE && !FlushE;
    assign div_zero = ctrl_d.is_div && (SrcBE == '0);
    assign div_ovf  = ctrl_d.is_div && ctrl_d.signA && (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (&SrcBE);
    assign fast_res = div_zero ? (ctrl_d.sel_rem ? SrcAE : '1)
                               : (ctrl_d.sel_rem ? '0 : SrcAE);

    // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_acc = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: the XLEN+1-bit trial remainder always fits, since rem_q < divisor.
    assign shifted = {rem_q, acc_q[XLEN-1]};
    assign sub     = shifted - {1'b0, opnd_q};
    assign borrow  = sub[XLEN];
    assign rem_d   = borrow ? shifted[XLEN-1:0] : sub[XLEN-1:0];
    assign div_acc = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~borrow};

    assign acc_d    = is_div_q ? div_acc : mul_acc;
    assign prod     = neg_q ? -acc_d : acc_d;
    assign div_val  = sel_rem_q ? rem_d : acc_d[XLEN-1:0];
    assign div_res  = neg_q ? -div_val : div_val;
    assign calc_res = is_div_q ? div_res : (sel_high_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]);

    assign BusyE   = start || (state_q == CALC);
    assign DoneE   = done_q;
    assign ResultE = result_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            is_div_q   <= 1'b0;
            sel_high_q <= 1'b0;
            sel_rem_q  <= 1'b0;
            neg_q      <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            opnd_q     <= '0;
            rem_q      <= '0;
            acc_q      <= '0;
            result_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    is_div_q   <= ctrl_d.is_div;
                    sel_high_q <= ctrl_d.sel_high;
                    sel_rem_q  <= ctrl_d.sel_rem;
                    neg_q      <= ctrl_d.sel_rem ? negA : (negA ^ negB);
                    opnd_q     <= ctrl_d.is_div ? magB : magA;
                    acc_q      <= {{XLEN{1'b0}}, (ctrl_d.is_div ? magA : magB)};
                    rem_q      <= '0;
                    cnt_q      <= CNT_W'(XLEN);
                    if (div_zero || div_ovf) begin
                        state_q  <= DONE;
                        result_q <= fast_res;
                        done_q   <= 1'b1;
                    end else begin
                        state_q <= CALC;
                    end
                end
                CALC: if (FlushE) begin
                    state_q <= IDLE;
                end else begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q  <= DONE;
                        result_q <= calc_res;
                        done_q   <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq (XLEN=32): latency, results, flush and reset behaviour.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset, StartE, FlushE;
    logic [2:0]  funct3E;
    logic [31:0] SrcAE, SrcBE;
    logic        BusyE, DoneE;
    logic [31:0] ResultE;

    int checks = 0;
    int failures = 0;

    mdu_seq #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .StartE(StartE), .funct3E(funct3E),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
        .BusyE(BusyE), .DoneE(DoneE), .ResultE(ResultE)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start one op in the current IDLE cycle, wait for DoneE, check latency and result.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int n;
        StartE = 1'b1; funct3E = f3; SrcAE = a; SrcBE = b;
        tick();
        StartE = 1'b0;
        n = 1;
        while (!DoneE && n < 100) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " result"}, ResultE, exp_res);
        tick();
    endtask

    initial begin
        int  n;
        logic ok;
        reset = 1'b1; StartE = 1'b0; FlushE = 1'b0; funct3E = '0; SrcAE = '0; SrcBE = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset DoneE", {31'b0, DoneE}, 32'd0);
        chk("reset ResultE", ResultE, 32'd0);
        chk("reset BusyE", {31'b0, BusyE}, 32'd0);

        // MUL 7 * -3 with cycle-by-cycle busy/done watch
        StartE = 1'b1; funct3E = 3'b000; SrcAE = 32'd7; SrcBE = 32'hFFFF_FFFD;
        #1;
        chk("mul busy c0", {31'b0, BusyE}, 32'd1);
        tick();
        StartE = 1'b0;
        ok = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            if (BusyE !== 1'b1 || DoneE !== 1'b0) ok = 1'b0;
            tick();
        end
        chk("mul busy c1..32", {31'b0, ok}, 32'd1);
        chk("mul done c33", {31'b0, DoneE}, 32'd1);
        chk("mul busy c33", {31'b0, BusyE}, 32'd0);
        chk("mul result", ResultE, 32'hFFFF_FFEB);
        tick();
        chk("mul done pulse", {31'b0, DoneE}, 32'd0);

        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu",   3'b101, 32'd100,       32'd7,         32'd14,        33);
        run_op("divu0",  3'b101, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu0",  3'b111, 32'h1234_5678, 32'd0,         32'h1234_5678, 1);
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);

        // Flush at cycle 10 of a MUL; restart at cycle 12
        StartE = 1'b1; funct3E = 3'b000; SrcAE = 32'd9; SrcBE = 32'd9;
        tick();
        StartE = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        chk("flush idle c11", {31'b0, BusyE}, 32'd0);
        chk("flush no done c11", {31'b0, DoneE}, 32'd0);
        chk("flush result held", ResultE, 32'h4000_0000);
        tick();
        run_op("post-flush mul", 3'b000, 32'd3, 32'd5, 32'd15, 33);

        // REMU 10/3 with StartE held high: DoneE period 34
        StartE = 1'b1; funct3E = 3'b111; SrcAE = 32'd10; SrcBE = 32'd3;
        n = 0;
        do begin tick(); n++; end while (!DoneE && n < 200);
        chk("remu first latency", 32'(n), 32'd33);
        chk("remu first result", ResultE, 32'd1);
        n = 0;
        do begin tick(); n++; end while (!DoneE && n < 200);
        chk("remu period", 32'(n), 32'd34);
        chk("remu second result", ResultE, 32'd1);

        // Reset mid-CALC of the third REMU
        for (int c = 0; c < 6; c++) tick();
        reset = 1'b1;
        tick();
        chk("midcalc reset DoneE", {31'b0, DoneE}, 32'd0);
        chk("midcalc reset ResultE", ResultE, 32'd0);
        reset = 1'b0; StartE = 1'b0;
        tick();
        chk("post reset idle", {31'b0, BusyE}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
